matrix_mem_bank: RTL and testbench
==================================

# matrix_mem_bank

Parametrised matrix storage bank for the matrix multiplier datapath. It holds one ROWS×COLS matrix of WIDTH-bit elements with (row, col) addressing. Ports:
- a synchronous write port;
- a registered random-read port;
- a valid/ready streaming port that emits a whole row or column, which feeds the multiply-accumulate lanes.

After reset, a built-in sequencer clears the whole array to zero, one entry per cycle.

## Interface
- ROWS, 2, number of matrix rows (≥1)
- COLS, 2, number of matrix columns (≥1)
- WIDTH, 8, element width in bits
- RAW, max(1,$clog2(ROWS)), row address width (derived localparam)
- CAW, max(1,$clog2(COLS)), column address width (derived localparam)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write strobe
- wr_row  in  RAW  write row
- wr_col  in  CAW  write column
- wr_data  in  WIDTH  write value
- rd_en  in  1  random-read strobe
- rd_row  in  RAW  read row
- rd_col  in  CAW  read column
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  rd_data valid pulse
- burst_start  in  1  start stream request
- burst_dir  in  1  0 = stream row burst_idx, 1 = stream column burst_idx
- burst_idx  in  max(RAW,CAW)  row/column selector
- burst_err  out  1  one-cycle pulse: burst_start rejected for out-of-range index
- burst_busy  out  1  stream in progress
- s_data  out  WIDTH  stream element
- s_valid  out  1  stream element valid
- s_ready  in  1  downstream accepts element
- s_last  out  1  marks final element of the burst
- init_busy  out  1  clear sequencer active

## Operation
- **FSM states:** INIT, IDLE, BURST.
- **rst:** forces INIT and clears the entry counter. All outputs reset to 0 except init_busy, which resets to 1.
- **INIT:** writes 0 to flat entry r*COLS+c, counter 0..ROWS*COLS-1, one entry per cycle. After the last entry the FSM moves to IDLE and init_busy falls.
  - wr_en, rd_en and burst_start are ignored in INIT.
  - rd_valid stays 0 in INIT.
- **Write (IDLE or BURST):** wr_en with wr_row<ROWS and wr_col<COLS stores wr_data at the clock edge. An out-of-range write is dropped silently.
- **Random read (IDLE or BURST):** rd_en loads rd_data with the addressed element and pulses rd_valid.
  - Out-of-range address: rd_data=0, rd_valid=1.
  - rd_data holds its value when rd_en=0.
- **Read-before-write:** a read or stream fetch of the address being written in the same cycle returns the old value.
- **Burst start (IDLE only):** burst_start latches burst_dir and burst_idx.
  - Row burst: length COLS, elements (idx,0..COLS-1).
  - Column burst: length ROWS, elements (0..ROWS-1,idx).
  - burst_idx ≥ ROWS (row) or ≥ COLS (column): no burst, burst_err pulses for one cycle.
  - burst_start in BURST or INIT: ignored, and no burst_err.
- **BURST:**
  - Output register pattern: s_valid/s_data/s_last hold their values while s_ready=0.
  - On s_valid&&s_ready the next element loads on the same edge, so there are no bubbles.
  - s_last=1 exactly on the final element.
  - On the final handshake s_valid clears and the FSM returns to IDLE.
  - burst_busy=1 for the whole of BURST.
- **Element fetch time:** each element's value is the memory content at the edge it loads into s_data. A write to a not-yet-emitted element is therefore visible in the stream.
- **Single-element bursts:** bursts with COLS=1 or ROWS=1 emit one element with s_last=1.

## Timing
- Clear: init_busy=1 from the rst edge through ROWS*COLS cycles after rst deasserts. The first accepted command is on cycle ROWS*COLS+1.
- Write latency 1: data is readable by an rd_en in the cycle after wr_en.
- Read latency 1: rd_en at edge t gives rd_data/rd_valid from t+1; rd_valid is high for one cycle per rd_en.
- Burst: burst_start sampled at edge t gives s_valid=1 with element 0 from t+1.
- Throughput: 1 element/cycle while s_ready=1. A full row burst with s_ready held high takes COLS cycles.
- A new burst_start is accepted no earlier than the cycle after the final handshake (FSM in IDLE).
- burst_err is asserted the cycle after the rejected burst_start.
- rst mid-burst: at the next edge s_valid, s_last and burst_busy drop to 0 and the FSM re-enters INIT. Contents are re-cleared.

## Test plan
- **Reset clear, ROWS=COLS=2:** pulse rst for 1 cycle, read all 4 entries once init_busy=0 -> init_busy high exactly 4 cycles after rst falls; all reads return 0.
- **Write/read:** write 0x5A to (1,0), rd_en (1,0) the next cycle -> rd_data=0x5A, rd_valid one cycle. Read (1,1) -> 0. Out-of-range write with ROWS=3 (row 3) -> no entry changes.
- **Row burst, ROWS=COLS=3, s_ready=1:** entries (2,c)=10+c, burst_start dir=0 idx=2 -> s_data 10,11,12 on 3 consecutive cycles, s_last on 12, burst_busy falls the next cycle.
- **Column burst with backpressure:** dir=1 idx=1, s_ready toggling 1,0,0,1,1 -> each element held stable while stalled, 3 elements in order, no drops or duplicates.
- **Collisions:** during a row burst, write element (2,2) before it is emitted -> stream shows the new value. Same-cycle rd_en/wr_en to one address -> old value. burst_start idx=3 with ROWS=3 -> burst_err pulse, no s_valid.
- **Reset mid-burst:** assert rst after 1 handshake of a 3-element burst -> s_valid=0 at the next edge, init_busy=1, memory reads 0 after the clear.

Source files
------------

// File: rtl/matrix_mem_bank.sv
// matrix_mem_bank: ROWS x COLS matrix store with (row,col) write, registered random read and a row/column stream port.
// Latency: write visible to reads 1 cycle later; rd_data 1 cycle after rd_en; first stream element 1 cycle after burst_start.
// Backpressure: s_valid/s_data/s_last hold while s_ready=0; one element per cycle while s_ready=1, no bubbles.
//
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   wr_en/wr_row/wr_col/wr_data      synchronous write, out-of-range dropped
//   rd_en/rd_row/rd_col              random read request
//   rd_data/rd_valid                 registered read result (0 for out-of-range)
//   burst_start/burst_dir/burst_idx  stream request: dir 0 = row idx, dir 1 = column idx
//   burst_err                        one-cycle pulse for a rejected (out-of-range) request
//   burst_busy                       stream in progress
//   s_data/s_valid/s_ready/s_last    valid/ready stream output
//   init_busy                        post-reset clear in progress
module matrix_mem_bank #(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int WIDTH = 8,
  localparam int RAW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CAW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int IW  = (RAW > CAW) ? RAW : CAW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [RAW-1:0]   wr_row,
  input  logic [CAW-1:0]   wr_col,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [RAW-1:0]   rd_row,
  input  logic [CAW-1:0]   rd_col,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             burst_start,
  input  logic             burst_dir,
  input  logic [IW-1:0]    burst_idx,
  output logic             burst_err,
  output logic             burst_busy,
  output logic [WIDTH-1:0] s_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic             s_last,
  output logic             init_busy
);

  localparam int N  = ROWS * COLS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  // Element counter must be able to hold max(ROWS,COLS), which is <= 2**IW.
  localparam int KW = IW + 1;
  localparam logic [AW-1:0] LAST_ENTRY = AW'(N - 1);

  typedef enum logic [1:0] {INIT, IDLE, BURST} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem [N];
  logic [AW-1:0]    init_cnt;

  // Latched burst descriptor and index of the element to load next.
  logic             b_dir;
  logic [IW-1:0]    b_idx;
  logic [KW-1:0]    b_cnt;

  // Control strobes decoded from the state.
  logic clr_en;
  logic cmd_ok;
  logic start_ok;
  logic start_err;
  logic hs;

  logic wr_in_range;
  logic rd_in_range;
  logic start_in_range;
  int   start_len;
  int   b_len;

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] nxt_addr;

  // Row-major flattening of (row, col).
  function automatic logic [AW-1:0] flat(input int r, input int c);
    return AW'(r * COLS + c);
  endfunction

  assign wr_in_range    = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
  assign rd_in_range    = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);
  assign start_in_range = burst_dir ? (32'(burst_idx) < COLS) : (32'(burst_idx) < ROWS);
  assign start_len      = burst_dir ? ROWS : COLS;
  assign b_len          = b_dir ? ROWS : COLS;

  assign wr_addr    = flat(32'(wr_row), 32'(wr_col));
  assign rd_addr    = flat(32'(rd_row), 32'(rd_col));
  assign start_addr = burst_dir ? flat(0, 32'(burst_idx)) : flat(32'(burst_idx), 0);
  assign nxt_addr   = b_dir ? flat(32'(b_cnt), 32'(b_idx)) : flat(32'(b_idx), 32'(b_cnt));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_cnt == LAST_ENTRY) state_nxt = IDLE;
      IDLE:    if (burst_start && start_in_range) state_nxt = BURST;
      BURST:   if (s_valid && s_ready && s_last) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    init_busy  = (state == INIT);
    burst_busy = (state == BURST);
    clr_en     = (state == INIT);
    cmd_ok     = (state != INIT);
    start_ok   = (state == IDLE) && burst_start && start_in_range;
    start_err  = (state == IDLE) && burst_start && !start_in_range;
    hs         = (state == BURST) && s_valid && s_ready;
  end

  // ---------------------------------------------------------------- clear counter
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
    end else if (clr_en) begin
      init_cnt <= (init_cnt == LAST_ENTRY) ? '0 : init_cnt + AW'(1);
    end
  end

  // ---------------------------------------------------------------- storage
  // Reads below use the pre-edge contents, so a same-cycle read/fetch of the
  // entry being written returns the old value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en)
        mem[init_cnt] <= '0;
      else if (wr_en && wr_in_range)
        mem[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------- random read
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (cmd_ok && rd_en) begin
      rd_valid <= 1'b1;
      rd_data  <= rd_in_range ? mem[rd_addr] : '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- stream
  // Each element is fetched on the edge it enters s_data, so writes to
  // elements not yet emitted show up in the stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid   <= 1'b0;
      s_last    <= 1'b0;
      s_data    <= '0;
      b_dir     <= 1'b0;
      b_idx     <= '0;
      b_cnt     <= '0;
      burst_err <= 1'b0;
    end else begin
      burst_err <= start_err;
      if (start_ok) begin
        b_dir   <= burst_dir;
        b_idx   <= burst_idx;
        b_cnt   <= KW'(1);
        s_valid <= 1'b1;
        s_data  <= mem[start_addr];
        s_last  <= (start_len == 1);
      end else if (hs) begin
        if (s_last) begin
          s_valid <= 1'b0;
          s_last  <= 1'b0;
        end else begin
          s_data <= mem[nxt_addr];
          s_last <= (32'(b_cnt) == b_len - 1);
          b_cnt  <= b_cnt + KW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_mem_bank.sv
// Directed bench for a 3x3, 8-bit matrix_mem_bank: clear, write/read, row and
// column streams with backpressure, collisions, rejected bursts, reset mid-burst.
module tb_matrix_mem_bank;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [1:0] wr_col;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [1:0] rd_row;
  logic [1:0] rd_col;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       burst_start;
  logic       burst_dir;
  logic [1:0] burst_idx;
  logic       burst_err;
  logic       burst_busy;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_last;
  logic       init_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [9];

  matrix_mem_bank #(.ROWS(3), .COLS(3), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .burst_start(burst_start), .burst_dir(burst_dir), .burst_idx(burst_idx),
    .burst_err(burst_err), .burst_busy(burst_busy),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int r, input int c, input logic [7:0] v);
    wr_en = 1'b1; wr_row = 2'(r); wr_col = 2'(c); wr_data = v;
    tick;
    wr_en = 1'b0;
    if (r < 3 && c < 3) model[r*3+c] = v;
  endtask

  task automatic do_read(input int r, input int c, input logic [7:0] exp, input string tag);
    rd_en = 1'b1; rd_row = 2'(r); rd_col = 2'(c);
    tick;
    rd_en = 1'b0;
    chk({tag, "_valid"}, rd_valid, 1);
    chk(tag, rd_data, exp);
  endtask

  task automatic chk_s(input string tag, input logic v, input logic [7:0] d, input logic l);
    chk({tag, "_s_valid"}, s_valid, v);
    chk({tag, "_s_data"}, s_data, d);
    chk({tag, "_s_last"}, s_last, l);
  endtask

  task automatic wait_init(input string tag);
    int cnt;
    cnt = 0;
    while (init_busy === 1'b1 && cnt < 30) begin
      tick;
      cnt++;
      chk({tag, "_rd_valid"}, rd_valid, 0);
      chk({tag, "_s_valid"}, s_valid, 0);
    end
    chk({tag, "_cycles"}, cnt, 9);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 9; i++) do_read(i / 3, i % 3, model[i], tag);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    rd_en = 1'b0; rd_row = '0; rd_col = '0;
    burst_start = 1'b0; burst_dir = 1'b0; burst_idx = '0; s_ready = 1'b0;
    for (int i = 0; i < 9; i++) model[i] = 8'h00;

    // Reset state
    tick;
    rst = 1'b0;
    chk("rst_init_busy", init_busy, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_burst_busy", burst_busy, 0);
    chk("rst_burst_err", burst_err, 0);
    chk_s("rst", 1'b0, 8'h00, 1'b0);

    // Commands issued during the clear must all be ignored.
    wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'hFF;
    rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd0;
    burst_start = 1'b1; burst_dir = 1'b0; burst_idx = 2'd0; s_ready = 1'b1;
    wait_init("init");
    wr_en = 1'b0; rd_en = 1'b0; burst_start = 1'b0;
    tick;
    chk("idle_s_valid", s_valid, 0);
    chk("idle_burst_busy", burst_busy, 0);
    chk("idle_burst_err", burst_err, 0);
    read_all("clear_rd");

    // Write then read next cycle; rd_valid pulses once and rd_data holds.
    do_write(1, 0, 8'h5A);
    do_read(1, 0, 8'h5A, "wr_rd_10");
    tick;
    chk("rd_valid_pulse", rd_valid, 0);
    chk("rd_data_hold", rd_data, 8'h5A);
    do_read(1, 1, 8'h00, "rd_11");

    // Out-of-range write dropped; out-of-range read returns 0 with valid.
    do_write(3, 0, 8'h77);
    do_write(0, 3, 8'h66);
    read_all("oor_wr");
    do_read(3, 0, 8'h00, "oor_rd");

    // Row burst with s_ready high: three consecutive elements.
    do_write(2, 0, 8'd10);
    do_write(2, 1, 8'd11);
    do_write(2, 2, 8'd12);
    s_ready = 1'b1;
    burst_start = 1'b1; burst_dir = 1'b0; burst_idx = 2'd2;
    tick;
    burst_start = 1'b0;
    chk_s("row_e0", 1'b1, 8'd10, 1'b0);
    chk("row_busy", burst_busy, 1);
    tick;
    chk_s("row_e1", 1'b1, 8'd11, 1'b0);
    tick;
    chk_s("row_e2", 1'b1, 8'd12, 1'b1);
    chk("row_busy_last", burst_busy, 1);
    tick;
    chk("row_done_valid", s_valid, 0);
    chk("row_done_last", s_last, 0);
    chk("row_done_busy", burst_busy, 0);

    // Column burst with s_ready pattern 1,0,0,1,1.
    do_write(0, 1, 8'h21);
    do_write(1, 1, 8'h22);
    s_ready = 1'b0;
    burst_start = 1'b1; burst_dir = 1'b1; burst_idx = 2'd1;
    tick;
    burst_start = 1'b0;
    chk_s("col_e0", 1'b1, 8'h21, 1'b0);
    s_ready = 1'b1;
    tick;
    chk_s("col_e1", 1'b1, 8'h22, 1'b0);
    s_ready = 1'b0;
    burst_start = 1'b1; burst_dir = 1'b0; burst_idx = 2'd3;
    tick;
    burst_start = 1'b0;
    chk_s("col_stall1", 1'b1, 8'h22, 1'b0);
    chk("col_busy_start_no_err", burst_err, 0);
    tick;
    chk_s("col_stall2", 1'b1, 8'h22, 1'b0);
    chk("col_no_err2", burst_err, 0);
    s_ready = 1'b1;
    tick;
    chk_s("col_e2", 1'b1, 8'd11, 1'b1);
    tick;
    chk("col_done_valid", s_valid, 0);
    chk("col_done_busy", burst_busy, 0);

    // Write to a not-yet-emitted element during a row burst.
    burst_start = 1'b1; burst_dir = 1'b0; burst_idx = 2'd2;
    tick;
    burst_start = 1'b0;
    chk_s("coll_e0", 1'b1, 8'd10, 1'b0);
    do_write(2, 2, 8'h99);
    chk_s("coll_e1", 1'b1, 8'd11, 1'b0);
    tick;
    chk_s("coll_e2", 1'b1, 8'h99, 1'b1);
    tick;
    chk("coll_done", s_valid, 0);

    // Same-cycle read and write of one address returns the old value.
    rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd0;
    wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'h44;
    tick;
    rd_en = 1'b0; wr_en = 1'b0;
    chk("rbw_valid", rd_valid, 1);
    chk("rbw_old", rd_data, 8'h00);
    model[0] = 8'h44;
    do_read(0, 0, 8'h44, "rbw_new");

    // Out-of-range burst requests pulse burst_err without streaming.
    burst_start = 1'b1; burst_dir = 1'b0; burst_idx = 2'd3;
    tick;
    burst_start = 1'b0;
    chk("err_row_pulse", burst_err, 1);
    chk("err_row_s_valid", s_valid, 0);
    chk("err_row_busy", burst_busy, 0);
    tick;
    chk("err_row_clear", burst_err, 0);
    chk("err_row_s_valid2", s_valid, 0);
    burst_start = 1'b1; burst_dir = 1'b1; burst_idx = 2'd3;
    tick;
    burst_start = 1'b0;
    chk("err_col_pulse", burst_err, 1);
    chk("err_col_s_valid", s_valid, 0);
    tick;
    chk("err_col_clear", burst_err, 0);

    // Reset after one handshake of a row burst.
    s_ready = 1'b1;
    burst_start = 1'b1; burst_dir = 1'b0; burst_idx = 2'd1;
    tick;
    burst_start = 1'b0;
    chk_s("mid_e0", 1'b1, 8'h5A, 1'b0);
    tick;
    chk_s("mid_e1", 1'b1, 8'h22, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_s_valid", s_valid, 0);
    chk("mid_rst_s_last", s_last, 0);
    chk("mid_rst_busy", burst_busy, 0);
    chk("mid_rst_init_busy", init_busy, 1);
    wait_init("reinit");
    for (int i = 0; i < 9; i++) model[i] = 8'h00;
    read_all("reclear_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
